mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one MUX8to1-selected datapath among 8 requesters.
//  Drives the 3-bit select of an 8:1 mux and a one-hot grant back to the requesters.
//  Counts accepted beats per tenure and forces release after MAX_BURST beats so no
//  requester can starve the others. Sits between the 8 bus masters and the shared mux/bus.
// PARAMETERS
//  MAX_BURST  4  beats per tenure before forced release; 1..255; 0 = unlimited
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  req        in   8  req[i]=1: requester i wants the shared path; held while it has data
//  out_ready  in   1  downstream accepts the muxed beat this cycle
//  grant      out  8  one-hot owner, registered; all-zero when no owner
//  sel        out  3  registered mux select = owner index; holds last owner when idle
//  busy       out  1  registered; 1 while an owner holds the path
//  xfer       out  1  combinational: busy & req[sel] & out_ready (beat accepted)
//  burst_end  out  1  registered 1-cycle pulse: cycle after a forced MAX_BURST release
// BEHAVIOUR
//  Reset: grant=0, sel=0, busy=0, burst_end=0, beat count=0, priority ptr=7.
//  The search therefore starts at index 0 after reset.
//  States: IDLE (busy=0), OWN (busy=1). Priority ptr = index of last owner.
//  Search order: ptr+1, ptr+2, ..., ptr (mod 8); the first set req bit wins.
//  IDLE: if any req, the next cycle is OWN with grant/sel = the winner and beat count=0.
//  IDLE: if no req, stay in IDLE; grant=0 and sel unchanged.
//  Latency: req rises in IDLE -> grant registered the next cycle (1 cycle).
//  OWN: each cycle with xfer=1 increments the beat count (8-bit).
//  OWN: out_ready=0 stalls; no count change and no release.
//  Release condition (evaluated in OWN):
//   a) req[sel]=0 (voluntary release), or
//   b) xfer=1 and count+1 == MAX_BURST, with MAX_BURST != 0 (forced release).
//  On release: ptr <= sel; re-arbitrate in the same cycle over req, excluding the
//   current owner for case b.
//   - If a winner exists: the next cycle is OWN with the new grant and count=0.
//     Back-to-back handoff costs no idle cycle.
//   - If no winner: the next cycle is IDLE.
//  Case b with no other requester: the owner may win again after one IDLE cycle,
//   provided its req is still set.
//  burst_end=1 for exactly the cycle after a case-b release.
//  A forced-release owner must not be regranted in the cycle right after its release
//   while another req is pending.
//  grant is always one-hot or zero; it never changes while OWN and no release is taken.
//  Requests that appear mid-tenure do not preempt the owner.
//  reset during OWN: the next cycle matches the reset state. Any in-flight beat count
//   is discarded and ptr returns to 7.
//  req bits are sampled only at the clock edge. Glitches between edges have no effect.
// TESTING
//  T1 reset: hold reset 2 cycles with req=8'hFF -> grant=0, sel=0, busy=0.
//     Release reset -> next cycle grant=8'h01.
//  T2 single: req=8'h20, out_ready=1, MAX_BURST=0 -> grant=8'h20, sel=5 after 1 cycle.
//     Drop req -> busy=0 next cycle and sel stays 5.
//  T3 rotation: req=8'h81 held, MAX_BURST=4, out_ready=1 -> grant 01 for 4 beats,
//     then 80 for 4 beats, then 01, with no idle cycles. burst_end pulses at each handoff.
//  T4 stall: owner 3, out_ready toggles 1,0,0,1,1,1 -> xfer only on ready cycles.
//     Release happens after the 4th accepted beat, not after 4 cycles.
//  T5 wrap: ptr=6 (last owner 6), req=8'h41 -> next owner 0 (search 7,0,...).
//     Then req=8'h41 again -> owner 6.
//  T6 mid-reset: assert reset during beat 2 of a tenure on owner 2 -> next cycle
//     grant=0, busy=0. After reset with req=8'h04 -> grant=8'h04 and the count restarts at 0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of a shared 8:1 mux path with burst-limited tenures
// ports: req[i] asks for the path; out_ready is downstream accept; grant is the one-hot owner;
//        sel is the mux select; busy means an owner holds the path; xfer means a beat was
//        accepted; burst_end pulses the cycle after a forced release
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       xfer,
  output logic       burst_end
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [7:0] MB = 8'(MAX_BURST);
  state_t state_q, state_d;
  logic [7:0] grant_q, grant_d, cnt_q, cnt_d, cand;
  logic [2:0] sel_q, sel_d, ptr_q, ptr_d, base, idx, win;
  logic be_q, be_d, forced, rel, win_v;
  assign xfer = state_q == OWN && req[sel_q] && out_ready;
  assign forced = xfer && MB != 8'd0 && cnt_q + 8'd1 == MB;
  assign rel = state_q == OWN && (!req[sel_q] || forced);
  // a forced owner is masked out so any other pending requester takes the handoff
  assign cand = req & ~(forced ? 8'b1 << sel_q : 8'b0);
  assign base = state_q == OWN ? sel_q : ptr_q;
  always_comb begin
    win_v = 1'b0;
    win = 3'd0;
    idx = 3'd0;
    // scan farthest-first so the nearest set bit after base is the one that sticks
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (cand[idx]) begin
        win_v = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d = sel_q;
    cnt_d = cnt_q + {7'd0, xfer};
    ptr_d = ptr_q;
    be_d = 1'b0;
    if (state_q == IDLE || rel) begin
      state_d = win_v ? OWN : IDLE;
      grant_d = win_v ? 8'b1 << win : 8'b0;
      sel_d = win_v ? win : sel_q;
      cnt_d = 8'd0;
    end
    if (rel) begin
      ptr_d = sel_q;
      be_d = forced;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 8'd0;
      sel_q <= 3'd0;
      cnt_q <= 8'd0;
      ptr_q <= 3'd7;
      be_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      be_q <= be_d;
    end
  end
  assign grant = grant_q;
  assign sel = sel_q;
  assign busy = state_q == OWN;
  assign burst_end = be_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed scoreboard bench for a burst-limited and an unlimited arbiter
module tb_mux8_rr_arbiter;
  logic clk = 1'b0;
  logic reset, out_ready;
  logic [7:0] req;
  logic [7:0] g4, g0;
  logic [2:0] s4, s0;
  logic b4, b0, x4, x0, e4, e0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    bit w;
    logic [7:0] g;
    logic [2:0] s;
    logic b;
    logic e;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  mux8_rr_arbiter #(.MAX_BURST(4)) u4 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .grant(g4), .sel(s4), .busy(b4), .xfer(x4), .burst_end(e4)
  );
  mux8_rr_arbiter #(.MAX_BURST(0)) u0 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .grant(g0), .sel(s0), .busy(b0), .xfer(x0), .burst_end(e0)
  );
  task automatic chk(input string tag, input string what, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s got %h exp %h", tag, what, got, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] r, input logic rdy, input logic rst, input bit w,
                     input logic [7:0] eg, input logic [2:0] es, input logic eb, input logic ee,
                     input logic ex, input string tag);
    exp_t e;
    req = r;
    out_ready = rdy;
    reset = rst;
    #1;
    if (!$isunknown(ex)) chk(tag, "xfer", {7'd0, w ? x0 : x4}, {7'd0, ex});
    e.tag = tag;
    e.w = w;
    e.g = eg;
    e.s = es;
    e.b = eb;
    e.e = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "grant", e.w ? g0 : g4, e.g);
    chk(e.tag, "sel", {5'd0, e.w ? s0 : s4}, {5'd0, e.s});
    chk(e.tag, "busy", {7'd0, e.w ? b0 : b4}, {7'd0, e.b});
    chk(e.tag, "burst_end", {7'd0, e.w ? e0 : e4}, {7'd0, e.e});
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    cyc(8'hFF, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1'bx, "t1_rst_a");
    cyc(8'hFF, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1'bx, "t1_rst_b");
    cyc(8'hFF, 0, 0, 0, 8'h01, 3'd0, 1, 0, 1'b0, "t1_first");
    cyc(8'h00, 1, 1, 1, 8'h00, 3'd0, 0, 0, 1'bx, "t2_rst");
    cyc(8'h20, 1, 0, 1, 8'h20, 3'd5, 1, 0, 1'b0, "t2_grant");
    for (int i = 0; i < 6; i++) cyc(8'h20, 1, 0, 1, 8'h20, 3'd5, 1, 0, 1'b1, "t2_unlimited");
    cyc(8'h00, 1, 0, 1, 8'h00, 3'd5, 0, 0, 1'b0, "t2_drop");
    cyc(8'h00, 1, 0, 1, 8'h00, 3'd5, 0, 0, 1'b0, "t2_idle");
    cyc(8'h00, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1'bx, "t3_rst");
    cyc(8'h81, 1, 0, 0, 8'h01, 3'd0, 1, 0, 1'b0, "t3_grant0");
    for (int i = 0; i < 3; i++) cyc(8'h81, 1, 0, 0, 8'h01, 3'd0, 1, 0, 1'b1, "t3_beat0");
    cyc(8'h81, 1, 0, 0, 8'h80, 3'd7, 1, 1, 1'b1, "t3_hand7");
    for (int i = 0; i < 3; i++) cyc(8'h81, 1, 0, 0, 8'h80, 3'd7, 1, 0, 1'b1, "t3_beat7");
    cyc(8'h81, 1, 0, 0, 8'h01, 3'd0, 1, 1, 1'b1, "t3_hand0");
    cyc(8'h81, 1, 0, 0, 8'h01, 3'd0, 1, 0, 1'b1, "t3_again0");
    cyc(8'h00, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1'bx, "t4_rst");
    cyc(8'h08, 1, 0, 0, 8'h08, 3'd3, 1, 0, 1'b0, "t4_grant");
    cyc(8'h08, 1, 0, 0, 8'h08, 3'd3, 1, 0, 1'b1, "t4_b1");
    cyc(8'h08, 0, 0, 0, 8'h08, 3'd3, 1, 0, 1'b0, "t4_stall1");
    cyc(8'h08, 0, 0, 0, 8'h08, 3'd3, 1, 0, 1'b0, "t4_stall2");
    cyc(8'h08, 1, 0, 0, 8'h08, 3'd3, 1, 0, 1'b1, "t4_b2");
    cyc(8'h08, 1, 0, 0, 8'h08, 3'd3, 1, 0, 1'b1, "t4_b3");
    cyc(8'h08, 1, 0, 0, 8'h00, 3'd3, 0, 1, 1'b1, "t4_b4_release");
    cyc(8'h08, 1, 0, 0, 8'h08, 3'd3, 1, 0, 1'b0, "t4_regrant");
    cyc(8'h00, 0, 1, 0, 8'h00, 3'd0, 0, 0, 1'bx, "t5_rst");
    cyc(8'h40, 0, 0, 0, 8'h40, 3'd6, 1, 0, 1'b0, "t5_own6");
    cyc(8'h00, 0, 0, 0, 8'h00, 3'd6, 0, 0, 1'b0, "t5_rel6");
    cyc(8'h41, 0, 0, 0, 8'h01, 3'd0, 1, 0, 1'b0, "t5_wrap0");
    cyc(8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 1'b0, "t5_rel0");
    cyc(8'h41, 0, 0, 0, 8'h40, 3'd6, 1, 0, 1'b0, "t5_own6b");
    cyc(8'h00, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1'bx, "t6_rst");
    cyc(8'h04, 1, 0, 0, 8'h04, 3'd2, 1, 0, 1'b0, "t6_grant");
    cyc(8'h04, 1, 0, 0, 8'h04, 3'd2, 1, 0, 1'b1, "t6_b1");
    cyc(8'h04, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1'b1, "t6_midrst");
    cyc(8'h04, 1, 0, 0, 8'h04, 3'd2, 1, 0, 1'b0, "t6_regrant");
    for (int i = 0; i < 3; i++) cyc(8'h04, 1, 0, 0, 8'h04, 3'd2, 1, 0, 1'b1, "t6_count");
    cyc(8'h04, 1, 0, 0, 8'h00, 3'd2, 0, 1, 1'b1, "t6_release");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
